// File: rtl/bcd_digit_serializer.sv
// Serializes a packed BCD word onto a digit-per-beat valid/ready stream,
// most significant digit first, with a 7-segment code per digit,
// optional leading-zero blanking and an overflow dash override.
module bcd_digit_serializer #(
  parameter int DECLEN = 9,
  parameter int LZS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DECLEN*4-1:0]   BCD,
  input  logic                  ovf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            DIGIT,
  output logic [6:0]            SEG,
  output logic                  blank,
  output logic                  out_last
);

  // state | meaning
  // IDLE  | waiting for a word; in_ready high (unless rst)
  // SEND  | presenting one registered digit per beat, MSD down to LSD

  localparam int IW = (DECLEN > 1) ? $clog2(DECLEN) : 1;
  localparam logic [IW-1:0] MSD_IDX = IW'(DECLEN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_nxt;
  logic [DECLEN*4-1:0] word;
  logic                ovf_q;
  logic [IW-1:0]       idx;
  logic                seen;

  logic                accept, advance;
  logic [3:0]          cur_nib, nxt_nib;
  logic [IW-1:0]       nxt_idx;
  logic                nxt_seen, nxt_ovf, nxt_last, nxt_blank;
  logic [3:0]          nxt_digit;
  logic [6:0]          nxt_seg;

  function automatic logic [3:0] nib_at(input logic [DECLEN*4-1:0] w,
                                        input logic [IW-1:0] i);
    nib_at = 4'h0;
    for (int k = 0; k < DECLEN; k++)
      if (i == IW'(k)) nib_at = w[k*4 +: 4];
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] n);
    case (n)
      4'd0:    seg_enc = 7'h3F;
      4'd1:    seg_enc = 7'h06;
      4'd2:    seg_enc = 7'h5B;
      4'd3:    seg_enc = 7'h4F;
      4'd4:    seg_enc = 7'h66;
      4'd5:    seg_enc = 7'h6D;
      4'd6:    seg_enc = 7'h7D;
      4'd7:    seg_enc = 7'h07;
      4'd8:    seg_enc = 7'h7F;
      4'd9:    seg_enc = 7'h6F;
      default: seg_enc = 7'h40;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept a word in IDLE, return after the LSD handshake
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SEND;
      SEND: if (advance && idx == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; in_ready is forced low while reset is asserted
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == SEND);
  end

  assign accept  = in_valid && in_ready;
  assign advance = out_valid && out_ready;

  // Next beat: the MSD of the incoming word when accepting, else the next
  // lower digit of the captured word. seen covers beats already presented.
  always_comb begin
    cur_nib = nib_at(word, idx);
    if (state == IDLE) begin
      nxt_idx  = MSD_IDX;
      nxt_nib  = nib_at(BCD, MSD_IDX);
      nxt_seen = 1'b0;
      nxt_ovf  = ovf;
    end else begin
      nxt_idx  = idx - IW'(1);
      nxt_nib  = nib_at(word, nxt_idx);
      nxt_seen = seen | (cur_nib != 4'h0);
      nxt_ovf  = ovf_q;
    end
    nxt_last  = (nxt_idx == '0);
    nxt_blank = 1'b0;
    nxt_digit = nxt_nib;
    nxt_seg   = seg_enc(nxt_nib);
    if (nxt_ovf) begin
      nxt_digit = 4'hF;
      nxt_seg   = 7'h40;
    end else if ((LZS != 0) && nxt_nib == 4'h0 && !nxt_seen && !nxt_last) begin
      nxt_blank = 1'b1;
      nxt_digit = 4'h0;
      nxt_seg   = 7'h00;
    end
  end

  // Capture and beat registers; outputs are loaded only on accept/advance
  always_ff @(posedge clk) begin
    if (rst) begin
      word     <= '0;
      ovf_q    <= 1'b0;
      idx      <= '0;
      seen     <= 1'b0;
      DIGIT    <= 4'h0;
      SEG      <= 7'h00;
      blank    <= 1'b0;
      out_last <= 1'b0;
    end else if (accept || (advance && idx != '0)) begin
      if (accept) begin
        word  <= BCD;
        ovf_q <= ovf;
      end
      idx      <= nxt_idx;
      seen     <= nxt_seen;
      DIGIT    <= nxt_digit;
      SEG      <= nxt_seg;
      blank    <= nxt_blank;
      out_last <= nxt_last;
    end
  end

endmodule
